p_counter_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one p_counter instance among NREQ requesters.

---
 rtl/p_counter_arb_if.sv | 44 ++++
 rtl/p_counter_arb.sv | 221 ++++++++++++++++++++++
 tb/tb_p_counter_arb.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/p_counter_arb_if.sv
// p_counter_arb_if: bundle of the requester, counter and response signals
// around p_counter_arb.
//   slave  modport : arbiter side (takes requests, drives counter strobes, answers)
//   master modport : environment side (requesters, counter, response consumer)
// Signals:
//   req_valid[NREQ], req_op[2*NREQ], req_data[WIDTH*NREQ], req_ready[NREQ]
//   cnt_set, cnt_up, cnt_down, cnt_set_value[WIDTH], cnt_count[WIDTH+2]
//   rsp_valid, rsp_ready, rsp_id[$clog2(NREQ)], rsp_count[WIDTH+2], rsp_err
interface p_counter_arb_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned ID_W = $clog2(NREQ);
  localparam int unsigned CW   = WIDTH + 2;

  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]       req_ready;

  logic                  cnt_set;
  logic                  cnt_up;
  logic                  cnt_down;
  logic [WIDTH-1:0]      cnt_set_value;
  logic [CW-1:0]         cnt_count;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [CW-1:0]         rsp_count;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_op, req_data, cnt_count, rsp_ready,
    output req_ready, cnt_set, cnt_up, cnt_down, cnt_set_value,
           rsp_valid, rsp_id, rsp_count, rsp_err
  );

  modport master (
    output req_valid, req_op, req_data, cnt_count, rsp_ready,
    input  req_ready, cnt_set, cnt_up, cnt_down, cnt_set_value,
           rsp_valid, rsp_id, rsp_count, rsp_err
  );
endinterface

// File: rtl/p_counter_arb.sv
// p_counter_arb: shares one p_counter among NREQ requesters.
// A requester's READ/UP/DOWN/SET command is granted round-robin, turned into
// a single-cycle strobe on the counter, and the post-update count is handed
// back on a held valid/ready response channel. One command is in flight.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; aborts any command, clears all state
//   bus    - p_counter_arb_if.slave (requests, counter strobes, response)
//
// Build option:
//   CNT_ARB_FIXED_PRIO_EN - lowest valid index always wins; rr_ptr pinned at 0.
//
// Op encoding on req_op: 00 READ, 01 UP, 10 DOWN, 11 SET.
// Sequence per command: IDLE (grant) -> ISSUE (ready + strobe) ->
// SETTLE (capture count) -> RESP (wait rsp_ready).
module p_counter_arb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic            clk,
  input  logic            reset,
  p_counter_arb_if.slave  bus
);

  localparam int unsigned ID_W = $clog2(NREQ);
  localparam int unsigned CW   = WIDTH + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_SET  = 2'b11;

  // State and registered outputs
  logic [1:0]       state_q,     state_d;
  logic [ID_W-1:0]  grant_q,     grant_d;
  logic [1:0]       op_q,        op_d;
  logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic             err_q,       err_d;
  logic [NREQ-1:0]  req_ready_q, req_ready_d;
  logic             set_q,       set_d;
  logic             up_q,        up_d;
  logic             down_q,      down_d;
  logic [WIDTH-1:0] set_value_q, set_value_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
  logic [CW-1:0]    rsp_count_q, rsp_count_d;
  logic             rsp_err_q,   rsp_err_d;

  // Arbitration results
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [1:0]       pick_op;
  logic [WIDTH-1:0] pick_data;
  logic [NREQ-1:0]  pick_onehot;
  int unsigned      cand;
  logic [ID_W-1:0]  rr_next;

  // Cyclic search for the first valid requester at or after rr_ptr.
  // In fixed-priority builds rr_ptr never leaves 0, so this is lowest-index-first.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = 32'(rr_ptr_q) + 32'(k);
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!pick_found && bus.req_valid[ID_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(cand);
      end
    end
  end

  // Select the winner's op/data and build its one-hot ready
  always_comb begin
    pick_op     = '0;
    pick_data   = '0;
    pick_onehot = NREQ'(1) << pick_idx;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == ID_W'(k)) begin
        pick_op   = bus.req_op[2*k +: 2];
        pick_data = bus.req_data[WIDTH*k +: WIDTH];
      end
    end
  end

  // Pointer just past the current winner, wrapping at NREQ
  always_comb begin
    rr_next = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + ID_W'(1);
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    op_d        = op_q;
    rr_ptr_d    = rr_ptr_q;
    err_d       = err_q;
    req_ready_d = '0;
    set_d       = 1'b0;
    up_d        = 1'b0;
    down_d      = 1'b0;
    set_value_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_count_d = rsp_count_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      // Grant and latch; ready/strobe registers go high for the ISSUE cycle
      S_IDLE: begin
        if (pick_found) begin
          state_d     = S_ISSUE;
          grant_d     = pick_idx;
          op_d        = pick_op;
          req_ready_d = pick_onehot;
          case (pick_op)
            OP_READ: begin
            end
            OP_UP: begin
              up_d = 1'b1;
            end
            OP_DOWN: begin
              down_d = 1'b1;
            end
            OP_SET: begin
              set_d       = 1'b1;
              set_value_d = pick_data;
            end
          endcase
        end
      end

      // Counter still shows the pre-update value here, so judge wrap/underflow now
      S_ISSUE: begin
        state_d = S_SETTLE;
        err_d   = ((op_q == OP_DOWN) && (bus.cnt_count == '0)) ||
                  ((op_q == OP_UP)   && (&bus.cnt_count));
      end

      // Counter has taken the strobe; capture the result
      S_SETTLE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = grant_q;
        rsp_count_d = bus.cnt_count;
        rsp_err_d   = err_q;
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
`ifdef CNT_ARB_FIXED_PRIO_EN
          rr_ptr_d    = '0;
`else
          rr_ptr_d    = rr_next;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      op_q        <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
      req_ready_q <= '0;
      set_q       <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      set_value_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      set_q       <= set_d;
      up_q        <= up_d;
      down_q      <= down_d;
      set_value_q <= set_value_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_count_q <= rsp_count_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.cnt_set       = set_q;
  assign bus.cnt_up        = up_q;
  assign bus.cnt_down      = down_q;
  assign bus.cnt_set_value = set_value_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_count     = rsp_count_q;
  assign bus.rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_p_counter_arb.sv
// Testbench for p_counter_arb (WIDTH=8, NREQ=4) with a behavioural counter
// and a command-level reference model of grants, counts and error flags.
module tb_p_counter_arb;
  localparam int W = 8;
  localparam int N = 4;
  localparam int CMAX = 1024;

  logic clk;
  logic reset;
  logic cnt_rst;
  logic [W+1:0] cnt;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  int   mc       = 0;
  int   model_rr = 0;
  logic [N-1:0] pend;
  logic [1:0]   pop   [N];
  logic [W-1:0] pdata [N];

  p_counter_arb_if #(.WIDTH(W), .NREQ(N)) bus ();

  p_counter_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter: set wins, UP wraps, DOWN saturates at 0
  always @(posedge clk or posedge cnt_rst) begin
    if (cnt_rst) cnt <= '0;
    else if (bus.cnt_set) cnt <= {2'b00, bus.cnt_set_value};
    else if (bus.cnt_up) cnt <= cnt + 10'd1;
    else if (bus.cnt_down && cnt != '0) cnt <= cnt - 10'd1;
  end
  assign bus.cnt_count = cnt;

  // Strobe protocol watch: at most one strobe, only alongside a ready
  always @(negedge clk) begin
    if (!reset) begin
      if (int'(bus.cnt_set) + int'(bus.cnt_up) + int'(bus.cnt_down) > 1) viol++;
      if ((bus.cnt_set | bus.cnt_up | bus.cnt_down) && bus.req_ready == '0) viol++;
      if (bus.cnt_set_value != '0 && !bus.cnt_set) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] strb(input logic [1:0] op);
    case (op)
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]       = pend[i];
      bus.req_op[2*i +: 2]   = pop[i];
      bus.req_data[W*i +: W] = pdata[i];
    end
  endtask

  task automatic post(input int i, input logic [1:0] op, input logic [W-1:0] d);
    pend[i] = 1'b1; pop[i] = op; pdata[i] = d;
    drive();
  endtask

  // New requests appear and waiting ones may change op/data before their grant
  task automatic mutate();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        pend[i]  = 1'b1;
        pop[i]   = 2'($urandom_range(0, 3));
        pdata[i] = 8'($urandom);
      end
    end
    drive();
  endtask

  function automatic logic [2:0] strobes();
    return {bus.cnt_set, bus.cnt_up, bus.cnt_down};
  endfunction

  // One full command from grant to response handshake; entered and left at a negedge in IDLE
  task automatic serve_one(input int hold, input bit mut);
    int eg, wn;
    logic [1:0] op;
    logic [W-1:0] d;
    logic [W+1:0] ecnt;
    logic eerr;
    eg = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (model_rr + k) % N;
      if (eg < 0 && pend[c]) eg = c;
    end
    if (eg < 0) eg = 0;
    wn = 0;
    while (bus.req_ready == '0 && wn < 20) begin
      @(negedge clk);
      wn++;
    end
    check("grant_latency", wn, 1);
    if (bus.req_ready == '0) return;
    check("ready_onehot", 32'(bus.req_ready), 32'(1) << eg);
    op = pop[eg];
    d  = pdata[eg];
    check("strobe_kind", 32'(strobes()), 32'(strb(op)));
    check("set_value", 32'(bus.cnt_set_value), (op == 2'b11) ? 32'(d) : 32'd0);
    eerr = 1'b0;
    case (op)
      2'b01: begin eerr = (mc == CMAX - 1); mc = (mc + 1) % CMAX; end
      2'b10: begin eerr = (mc == 0); if (mc > 0) mc = mc - 1; end
      2'b11: mc = int'(d);
      default: ;
    endcase
    ecnt = 10'(mc);
    @(negedge clk);
    pend[eg] = 1'b0;
    drive();
    check("ready_one_cycle", 32'(bus.req_ready), 0);
    check("strobe_one_cycle", 32'(strobes()), 0);
    check("no_early_rsp", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 1);
    check("rsp_id", 32'(bus.rsp_id), eg);
    check("rsp_count", 32'(bus.rsp_count), 32'(ecnt));
    check("rsp_err", 32'(bus.rsp_err), 32'(eerr));
    if (mut) mutate();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 1);
      check("hold_id", 32'(bus.rsp_id), eg);
      check("hold_count", 32'(bus.rsp_count), 32'(ecnt));
      check("hold_err", 32'(bus.rsp_err), 32'(eerr));
      check("hold_no_ready", 32'(bus.req_ready), 0);
      check("hold_no_strobe", 32'(strobes()), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
`ifndef CNT_ARB_FIXED_PRIO_EN
    model_rr = (eg + 1) % N;
`endif
    @(negedge clk);
    check("rsp_dropped", 32'(bus.rsp_valid), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_strobes"}, 32'(strobes()), 0);
    check({tag, "_set_value"}, 32'(bus.cnt_set_value), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
    check({tag, "_rsp_count"}, 32'(bus.rsp_count), 0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
  endtask

  initial begin
    int wn, guard;
    reset = 1'b1;
    cnt_rst = 1'b1;
    bus.rsp_ready = 1'b0;
    pend = '0;
    for (int i = 0; i < N; i++) begin pop[i] = 2'b00; pdata[i] = '0; end
    drive();
    #1 check_outputs_zero("reset_async");
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_held");
    reset = 1'b0;
    cnt_rst = 1'b0;

    // SET 0x2A from req0
    post(0, 2'b11, 8'h2A);
    serve_one(0, 1'b0);

    // DOWN at zero from req1
    post(0, 2'b11, 8'h00);
    serve_one(0, 1'b0);
    post(1, 2'b10, 8'h00);
    serve_one(0, 1'b0);

    // Climb to all-ones, then UP from req2 wraps
    post(0, 2'b11, 8'hFF);
    serve_one(0, 1'b0);
    repeat (CMAX - 1 - 255) begin
      post(3, 2'b01, 8'h00);
      serve_one(0, 1'b0);
    end
    post(2, 2'b01, 8'h00);
    serve_one(0, 1'b0);

    // Response back-pressure for 5 cycles while others request
    post(1, 2'b00, 8'h00);
    serve_one(5, 1'b1);
    guard = 0;
    while (pend != '0 && guard < 8) begin serve_one(0, 1'b0); guard++; end
    check("drain", 32'(pend), 0);

    // Leave rr_ptr past req1, then abort a req1 UP in SETTLE
    post(1, 2'b01, 8'h00);
    serve_one(0, 1'b0);
    post(1, 2'b01, 8'h00);
    wn = 0;
    while (bus.req_ready == '0 && wn < 20) begin @(negedge clk); wn++; end
    check("abort_ready", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    reset = 1'b1;
    #1 check_outputs_zero("reset_mid");
    mc = (mc + 1) % CMAX;
    model_rr = 0;
    pend = '0;
    drive();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_aborted_rsp", 32'(bus.rsp_valid), 0);
      check("idle_no_ready", 32'(bus.req_ready), 0);
    end

    // All four UP from a fresh pointer: grants in index order
    for (int i = 0; i < N; i++) post(i, 2'b01, 8'h00);
    for (int i = 0; i < N; i++) serve_one(0, 1'b0);

    // Randomized traffic
    repeat (150) begin
      if (pend == '0) post(int'($urandom_range(0, N - 1)), 2'($urandom_range(0, 3)), 8'($urandom));
      serve_one(int'($urandom_range(0, 3)), 1'b1);
    end
    guard = 0;
    while (pend != '0 && guard < 8) begin serve_one(0, 1'b0); guard++; end

    check("strobe_protocol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
